// File: rtl/rr_arbiter8_b32_if.sv
// rr_arbiter8_b32_if
//   Bundles the eight-requester input side and the valid/ready output stage of
//   the round-robin 8-to-1 word arbiter.
//   Signals:
//     req        [7:0]        requester i holds a word
//     req_data   [8*WIDTH-1:0] word i at [i*WIDTH +: WIDTH]
//     req_lock   [7:0]        burst-lock request (only with ARB_LOCK_EN)
//     gnt        [7:0]        one-hot accept, combinational
//     sel        [2:0]        mux select {C2,C1,C0}
//     out_valid               output register holds a word
//     out_data   [WIDTH-1:0]  registered selected word
//     out_src    [2:0]        requester that supplied out_data
//     out_ready               consumer accepts out_data
//   Modports: master = requesters + consumer side, slave = arbiter.
interface rr_arbiter8_b32_if #(
    parameter int WIDTH = 32
);
    logic [7:0]         req;
    logic [8*WIDTH-1:0] req_data;
    logic [7:0]         req_lock;
    logic [7:0]         gnt;
    logic [2:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_src;
    logic               out_ready;

    modport master (
        output req, req_data, req_lock, out_ready,
        input  gnt, sel, out_valid, out_data, out_src
    );

    modport slave (
        input  req, req_data, req_lock, out_ready,
        output gnt, sel, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_arbiter8_b32.sv
// rr_arbiter8_b32
//   Round-robin arbiter for a shared 8-to-1 WIDTH-bit word mux. Picks a winner
//   starting from the rotating pointer, drives the mux select and loads the
//   selected word into a single valid/ready output register.
//   Ports:
//     clk    rising-edge clock for all state
//     reset  synchronous, active-high
//     bus    rr_arbiter8_b32_if.slave (req/req_data/req_lock/gnt/sel and the
//            out_valid/out_data/out_src/out_ready output stage)
//   Optional feature macro: ARB_LOCK_EN enables burst lock of up to MAX_BURST
//   back-to-back grants to a requester holding req_lock. Undefined: pure round robin.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_EMPTY | output register empty, out_valid=0
//   ST_FULL  | output register holds a word, out_valid=1
module rr_arbiter8_b32 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    rr_arbiter8_b32_if.slave  bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state;
    logic [2:0]       ptr;
    logic [2:0]       ptr_nxt;
    logic [2:0]       sel_q;
    logic [2:0]       winner;
    logic [2:0]       idx;
    logic             found;
    logic             any_req;
    logic             can_load;
    logic             grant;
    logic [7:0]       gnt_w;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] out_data_q;
    logic [2:0]       out_src_q;

    // First requester at or after ptr, wrapping mod 8.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (winner == 3'(i)) begin
                win_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any_req  = |bus.req;
    assign can_load = (state == ST_EMPTY) | ((state == ST_FULL) & bus.out_ready);
    assign grant    = can_load & any_req & ~reset;

    always_comb begin
        gnt_w = '0;
        if (grant) begin
            gnt_w[winner] = 1'b1;
        end
    end

`ifdef ARB_LOCK_EN
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_eff;
    logic [CW-1:0] burst_nxt;

    // burst_cnt only counts grants to the previous winner; a new winner starts
    // its burst from zero. Hitting BURST_LAST breaks the lock and moves on.
    always_comb begin
        burst_eff = (winner == out_src_q) ? burst_cnt : '0;
        ptr_nxt   = winner + 3'd1;
        burst_nxt = '0;
        if (bus.req_lock[winner] && (burst_eff != BURST_LAST)) begin
            ptr_nxt   = winner;
            burst_nxt = burst_eff + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (grant) begin
            burst_cnt <= burst_nxt;
        end
    end
`else
    assign ptr_nxt = winner + 3'd1;

    // req_lock and MAX_BURST have no function without the burst lock.
    wire unused_lock = &{1'b0, bus.req_lock, (MAX_BURST > 0)};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_EMPTY;
            ptr        <= 3'd0;
            sel_q      <= 3'd0;
            out_data_q <= '0;
            out_src_q  <= 3'd0;
        end else begin
            if (any_req) begin
                sel_q <= winner;
            end
            if (grant) begin
                state      <= ST_FULL;
                out_data_q <= win_data;
                out_src_q  <= winner;
                ptr        <= ptr_nxt;
            end else if ((state == ST_FULL) && bus.out_ready) begin
                state <= ST_EMPTY;
            end
        end
    end

    // sel tracks the live winner and otherwise holds the last one.
    assign bus.sel       = reset ? 3'd0 : (any_req ? winner : sel_q);
    assign bus.gnt       = gnt_w;
    assign bus.out_valid = (state == ST_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_arbiter8_b32.sv
module tb_rr_arbiter8_b32;
    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [31:0] words [8];

    rr_arbiter8_b32_if #(.WIDTH(WIDTH)) bus ();

    rr_arbiter8_b32 #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words();
        for (int i = 0; i < 8; i++) begin
            bus.req_data[i*WIDTH +: WIDTH] = words[i];
        end
    endtask

    // Inputs already applied; expect a grant to idx this cycle and the word
    // registered one cycle later.
    task automatic grant_step(input string tag, input int idx);
        @(negedge clk);
        chk($sformatf("%s_gnt", tag), {24'd0, bus.gnt}, 32'(1) << idx);
        chk($sformatf("%s_sel", tag), {29'd0, bus.sel}, 32'(idx));
        tick();
        chk($sformatf("%s_valid", tag), {31'd0, bus.out_valid}, 32'd1);
        chk($sformatf("%s_src", tag), {29'd0, bus.out_src}, 32'(idx));
        chk($sformatf("%s_data", tag), bus.out_data, words[idx]);
    endtask

`ifdef ARB_LOCK_EN
    int lock_seq [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
`else
    int lock_seq [10] = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.req       = 8'h00;
        bus.req_lock  = 8'h00;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) words[i] = 32'hA5A5_0000 + 32'(i);

        // 1: reset, no requests
        tick();
        repeat (5) tick();
        @(negedge clk);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_gnt", {24'd0, bus.gnt}, 32'd0);
        chk("rst_sel", {29'd0, bus.sel}, 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_src", {29'd0, bus.out_src}, 32'd0);
        tick();
        bus.req       = 8'hFF;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_gnt", {24'd0, bus.gnt}, 32'd0);
        chk("rst_req_sel", {29'd0, bus.sel}, 32'd0);
        tick();
        chk("rst_req_valid", {31'd0, bus.out_valid}, 32'd0);

        // 2: single request
        reset    = 1'b0;
        words[0] = 32'hDEADBEEF;
        load_words();
        bus.req  = 8'h01;
        grant_step("t2", 0);
        bus.req = 8'h00;
        tick();
        chk("t2_drain", {31'd0, bus.out_valid}, 32'd0);

        // 3: all requesting, full rotation with no bubbles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) words[i] = 32'h1000_0000 + 32'(i * 16 + 1);
        load_words();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            grant_step($sformatf("t3_%0d", k), k % 8);
        end
        bus.req = 8'h00;
        tick();
        chk("t3_drain", {31'd0, bus.out_valid}, 32'd0);

        // 4: backpressure (ptr=1 here)
        bus.req = 8'h84;
        grant_step("t4a", 2);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t4_bp_gnt", {24'd0, bus.gnt}, 32'd0);
            chk("t4_bp_sel", {29'd0, bus.sel}, 32'd7);
            tick();
            chk("t4_bp_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("t4_bp_data", bus.out_data, words[2]);
            chk("t4_bp_src", {29'd0, bus.out_src}, 32'd2);
        end
        bus.out_ready = 1'b1;
        grant_step("t4b", 7);
        bus.req = 8'h00;
        @(negedge clk);
        chk("t4_sel_hold", {29'd0, bus.sel}, 32'd7);
        tick();
        chk("t4_drain", {31'd0, bus.out_valid}, 32'd0);

        // 5: pointer wrap from 7 (ptr=0 here)
        bus.req = 8'h40;
        grant_step("t5a", 6);
        bus.req = 8'h41;
        grant_step("t5b", 0);
        bus.req = 8'h00;
        tick();

        // 6: burst lock / plain alternation
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        bus.req      = 8'h06;
        bus.req_lock = 8'h02;
        for (int k = 0; k < 10; k++) begin
            grant_step($sformatf("t6_%0d", k), lock_seq[k]);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_gnt", {24'd0, bus.gnt}, 32'd0);
        tick();
        chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_data", bus.out_data, 32'd0);
        bus.req      = 8'h00;
        bus.req_lock = 8'h00;
        reset        = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
